// File: rtl/lock_pkg.sv
// Shared constants and types for the hardware lock table.
// Used by lock_arbiter and by the core-side lock controller so both agree
// on core count, lock count and index widths.
//   NCORE   : number of cores sharing the lock table
//   NLOCK   : number of hardware locks
//   LW / OW : lock-index width and owner-index width
package lock_pkg;

    localparam int NCORE = 4;
    localparam int NLOCK = 8;

    // Index width that never collapses to zero bits for a size of one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LW = idx_w(NLOCK);
    localparam int OW = idx_w(NCORE);

    typedef logic [OW-1:0] owner_t;
    typedef logic [LW-1:0] lock_idx_t;

endpackage

// File: rtl/lock_arbiter_rr.sv
// Round-robin selector for the lock arbiter.
// Scans the request vector starting at index ptr, wrapping modulo N, and
// returns a one-hot grant for the first set request (all zero if none).
//   req   : request vector, one bit per requester
//   ptr   : index that has highest priority this cycle
//   grant : one-hot grant
module rr_arbiter #(
    parameter int N  = 4,
    localparam int PW = lock_pkg::idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    import lock_pkg::*;

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_arbiter.sv
// Hardware lock table shared by NCORE cores.
// Each core holds a LOCK or UNLOCK request until it sees a one-cycle ack.
// One grantable request is served per cycle in round-robin order.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   lock_en    : per-core LOCK request
//   unlock_en  : per-core UNLOCK request
//   lock_id    : per-core target lock index
//   lock_ac    : per-core registered ack pulse
//   lock_held  : per-lock owned flag
//   lock_owner : per-lock owning core (0 when free)
//   unlock_err : per-core sticky flag for UNLOCK of a lock not owned
module lock_arbiter #(
    parameter int NCORE = lock_pkg::NCORE,
    parameter int NLOCK = lock_pkg::NLOCK,
    localparam int LW = lock_pkg::idx_w(NLOCK),
    localparam int OW = lock_pkg::idx_w(NCORE)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NCORE-1:0]          lock_en,
    input  logic [NCORE-1:0]          unlock_en,
    input  logic [NCORE-1:0][LW-1:0]  lock_id,
    output logic [NCORE-1:0]          lock_ac,
    output logic [NLOCK-1:0]          lock_held,
    output logic [NLOCK-1:0][OW-1:0]  lock_owner,
    output logic [NCORE-1:0]          unlock_err
);
    import lock_pkg::*;

    logic [OW-1:0]    last_grant;
    logic [OW-1:0]    start_ptr;
    logic [NCORE-1:0] eligible;
    logic [NCORE-1:0] grantable;
    logic [NCORE-1:0] owns;
    logic [NCORE-1:0] grant;
    logic [OW-1:0]    gidx;
    logic [LW-1:0]    gid;
    logic             any_grant;

    assign start_ptr = (last_grant == OW'(NCORE-1)) ? '0 : last_grant + 1'b1;

    // A core in its ack cycle is masked so the still-held request is not
    // granted a second time.
    always_comb begin
        eligible  = '0;
        grantable = '0;
        owns      = '0;
        for (int c = 0; c < NCORE; c++) begin
            eligible[c]  = (lock_en[c] | unlock_en[c]) & ~lock_ac[c];
            owns[c]      = lock_held[lock_id[c]] && (lock_owner[lock_id[c]] == OW'(c));
            grantable[c] = eligible[c] &
                           (unlock_en[c] | ~lock_held[lock_id[c]] | owns[c]);
        end
    end

    rr_arbiter #(.N(NCORE)) u_rr (
        .req   (grantable),
        .ptr   (start_ptr),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int c = 0; c < NCORE; c++) begin
            if (grant[c]) gidx = OW'(c);
        end
    end

    assign any_grant = |grant;
    assign gid       = lock_id[gidx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_ac    <= '0;
            lock_held  <= '0;
            lock_owner <= '0;
            unlock_err <= '0;
            last_grant <= OW'(NCORE-1);
        end else begin
            lock_ac <= grant;
            if (any_grant) begin
                last_grant <= gidx;
                if (lock_en[gidx]) begin
                    // Re-locking an own lock just acks.
                    if (!lock_held[gid]) begin
                        lock_held[gid]  <= 1'b1;
                        lock_owner[gid] <= gidx;
                    end
                end else if (owns[gidx]) begin
                    lock_held[gid]  <= 1'b0;
                    lock_owner[gid] <= '0;
                end else begin
                    unlock_err[gidx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_arbiter.sv
// Self-checking bench for lock_arbiter with a lock-table model.
module tb_lock_arbiter;
    localparam int NCORE = 4;
    localparam int NLOCK = 8;
    localparam int LW    = 3;
    localparam int OW    = 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NCORE-1:0]         lock_en = '0;
    logic [NCORE-1:0]         unlock_en = '0;
    logic [NCORE-1:0][LW-1:0] lock_id = '0;
    logic [NCORE-1:0]         lock_ac;
    logic [NLOCK-1:0]         lock_held;
    logic [NLOCK-1:0][OW-1:0] lock_owner;
    logic [NCORE-1:0]         unlock_err;

    int tests = 0;
    int fails = 0;

    lock_arbiter #(.NCORE(NCORE), .NLOCK(NLOCK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lock_en    (lock_en),
        .unlock_en  (unlock_en),
        .lock_id    (lock_id),
        .lock_ac    (lock_ac),
        .lock_held  (lock_held),
        .lock_owner (lock_owner),
        .unlock_err (unlock_err)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [NCORE-1:0] m_ack  = '0;
    logic [NCORE-1:0] m_err  = '0;
    logic [NLOCK-1:0] m_held = '0;
    int               m_owner [NLOCK];
    int               m_last = NCORE-1;

    initial for (int k = 0; k < NLOCK; k++) m_owner[k] = 0;

    // Winner among grantable requests, searched from the core after the
    // last winner; -1 when nobody can be served.
    function automatic int pick();
        for (int k = 1; k <= NCORE; k++) begin
            int c;
            int id;
            c  = (m_last + k) % NCORE;
            id = int'(lock_id[c]);
            if ((lock_en[c] || unlock_en[c]) && !m_ack[c] &&
                (unlock_en[c] || !m_held[id] || m_owner[id] == c))
                return c;
        end
        return -1;
    endfunction

    function automatic logic [NLOCK*OW-1:0] exp_owner();
        logic [NLOCK*OW-1:0] v;
        v = '0;
        for (int k = 0; k < NLOCK; k++) v[k*OW +: OW] = OW'(m_owner[k]);
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ack  <= '0;
            m_err  <= '0;
            m_held <= '0;
            m_last <= NCORE-1;
            for (int k = 0; k < NLOCK; k++) m_owner[k] <= 0;
        end else begin : upd
            automatic int g  = pick();
            automatic int id = (g >= 0) ? int'(lock_id[g]) : 0;
            m_ack <= '0;
            if (g >= 0) begin
                m_ack[g] <= 1'b1;
                m_last   <= g;
                if (lock_en[g]) begin
                    if (!m_held[id]) begin
                        m_held[id]  <= 1'b1;
                        m_owner[id] <= g;
                    end
                end else if (m_held[id] && m_owner[id] == g) begin
                    m_held[id]  <= 1'b0;
                    m_owner[id] <= 0;
                end else begin
                    m_err[g] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_ack",   64'(lock_ac),    64'(m_ack));
        check("model_held",  64'(lock_held),  64'(m_held));
        check("model_owner", 64'(lock_owner), 64'(exp_owner()));
        check("model_err",   64'(unlock_err), 64'(m_err));
        check("ack_onehot0", 64'($countones(lock_ac) <= 1), 64'd1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input int c, input bit is_lock, input int id);
        lock_id[c]   = LW'(id);
        lock_en[c]   = is_lock;
        unlock_en[c] = !is_lock;
    endtask

    task automatic drop(input int c);
        lock_en[c]   = 1'b0;
        unlock_en[c] = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_ac",    64'(lock_ac),    64'h0);
        check("rst_held",  64'(lock_held),  64'h0);
        check("rst_owner", 64'(lock_owner), 64'h0);
        reset_n = 1'b1;
        step();

        // single core lock / unlock
        req(0, 1, 3); step();
        check("s1_ack",   64'(lock_ac),    64'h1);
        check("s1_held",  64'(lock_held),  64'h08);
        check("s1_owner", 64'(lock_owner), 64'h0);
        drop(0); step();
        check("s1_ack_once", 64'(lock_ac), 64'h0);
        req(0, 0, 3); step();
        check("s1_unl_ack",  64'(lock_ac),   64'h1);
        check("s1_unl_held", 64'(lock_held), 64'h0);
        drop(0); step();

        // contention
        req(1, 1, 2); step();
        check("s2_c1_ack",   64'(lock_ac),    64'h2);
        check("s2_c1_owner", 64'(lock_owner), 64'h0010);
        drop(1); step();
        req(2, 1, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("s2_blocked", 64'(lock_ac), 64'h0);
        end
        req(1, 0, 2); step();
        check("s2_unl_ack", 64'(lock_ac), 64'h2);
        drop(1); step();
        check("s2_c2_ack",   64'(lock_ac),    64'h4);
        check("s2_c2_owner", 64'(lock_owner), 64'h0020);
        check("s2_c2_held",  64'(lock_held),  64'h04);
        drop(2); step();

        // unlock of a free lock
        req(3, 0, 5); step();
        check("s4_ack",  64'(lock_ac),    64'h8);
        check("s4_err",  64'(unlock_err), 64'h8);
        check("s4_held", 64'(lock_held),  64'h04);
        drop(3); step(); step();
        check("s4_sticky", 64'(unlock_err), 64'h8);

        // withdrawal
        req(0, 1, 4); step();
        check("s5_c0_ack", 64'(lock_ac),   64'h1);
        check("s5_held",   64'(lock_held), 64'h14);
        drop(0); step();
        req(1, 1, 4); step();
        check("s5_wait1", 64'(lock_ac), 64'h0);
        step();
        check("s5_wait2", 64'(lock_ac), 64'h0);
        drop(1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s5_no_late_ack", 64'(lock_ac), 64'h0);
        end

        // async reset while lock 4 held and a request pending
        req(1, 1, 4);
        #1 reset_n = 1'b0;
        #1;
        check("r_ac",    64'(lock_ac),    64'h0);
        check("r_held",  64'(lock_held),  64'h0);
        check("r_owner", 64'(lock_owner), 64'h0);
        check("r_err",   64'(unlock_err), 64'h0);
        drop(1); step();
        reset_n = 1'b1;
        step();
        check("r_no_ack", 64'(lock_ac), 64'h0);

        // fairness from reset
        for (int c = 0; c < NCORE; c++) req(c, 1, c);
        for (int c = 0; c < NCORE; c++) begin
            step();
            check("s3_rr_ack", 64'(lock_ac), 64'(1 << c));
            drop(c);
        end
        step();
        check("s3_ack_idle", 64'(lock_ac),    64'h0);
        check("s3_held",     64'(lock_held),  64'h0F);
        check("s3_owner",    64'(lock_owner), 64'h00E4);

        // unlock and competing lock of the same id in one cycle
        req(0, 0, 0);
        req(1, 1, 0);
        step();
        check("s6_unl_first", 64'(lock_ac),   64'h1);
        check("s6_held",      64'(lock_held), 64'h0E);
        drop(0); step();
        check("s6_lock_next", 64'(lock_ac),    64'h2);
        check("s6_owner",     64'(lock_owner), 64'h00E5);
        drop(1);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
